csr_exec_sequencer: RTL and testbench

//  Serialises CSR instructions inside the CSRU. It accepts one CSR op from the renamer and holds
//  it until the op is the oldest uncommitted instruction (ROB head). It then performs an atomic

---
 rtl/csr_exec_sequencer_if.sv | 42 ++++
 rtl/csr_exec_sequencer.sv | 140 ++++++++++++++
 tb/tb_csr_exec_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_exec_sequencer_if.sv
// Signal bundle around the CSR sequencer: renamer request, ROB head, CSR file port and writeback.
// master = surrounding pipeline/CSR file, slave = the sequencer.
interface csr_exec_sequencer_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_op;
  logic [11:0]      req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             req_wr;
  logic             rob_head_valid;
  logic [TAG_W-1:0] rob_head_tag;
  logic             flush;
  logic             csrf_rd_en;
  logic [11:0]      csrf_addr;
  logic [XLEN-1:0]  csrf_rdata;
  logic             csrf_illegal;
  logic             csrf_wr_en;
  logic [XLEN-1:0]  csrf_wdata;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic [XLEN-1:0]  done_rdata;
  logic             done_exc;
  logic             rename_stall;

  modport master (
    output req_valid, req_tag, req_op, req_addr, req_wdata, req_wr,
    output rob_head_valid, rob_head_tag, flush, csrf_rdata, csrf_illegal,
    input  req_ready, csrf_rd_en, csrf_addr, csrf_wr_en, csrf_wdata,
    input  done_valid, done_tag, done_rdata, done_exc, rename_stall
  );

  modport slave (
    input  req_valid, req_tag, req_op, req_addr, req_wdata, req_wr,
    input  rob_head_valid, rob_head_tag, flush, csrf_rdata, csrf_illegal,
    output req_ready, csrf_rd_en, csrf_addr, csrf_wr_en, csrf_wdata,
    output done_valid, done_tag, done_rdata, done_exc, rename_stall
  );
endinterface

// File: rtl/csr_exec_sequencer.sv
// Holds one CSR op until it reaches the ROB head, then performs an atomic read-modify-write
// on the CSR file and reports the old value and exception status to writeback.
module csr_exec_sequencer #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  csr_exec_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HEAD = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [1:0]       op_reg;
  logic [11:0]      addr_reg;
  logic [XLEN-1:0]  wdata_reg;
  logic             wr_reg;
  logic [XLEN-1:0]  old_reg;
  logic             exc_reg;
  logic             rd_en_reg;
  logic             wr_en_reg;
  logic [XLEN-1:0]  csrf_wdata_reg;
  logic             done_valid_reg;
  logic [TAG_W-1:0] done_tag_reg;
  logic [XLEN-1:0]  done_rdata_reg;
  logic             done_exc_reg;

  logic             accept;
  logic             head_match;
  logic             exc_next;
  logic [XLEN-1:0]  merge_next;

  assign bus.req_ready = (state_reg == IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign head_match    = bus.rob_head_valid && (bus.rob_head_tag == tag_reg);
  assign exc_next      = bus.csrf_illegal || (op_reg == 2'b11);

  // Per-bit merge of the freshly read CSR value; the reserved op falls through to the
  // RC form but its write is always suppressed by exc_next.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_merge
      assign merge_next[gi] = (op_reg == 2'b00) ? wdata_reg[gi] :
                              (op_reg == 2'b01) ? (bus.csrf_rdata[gi] | wdata_reg[gi]) :
                                                  (bus.csrf_rdata[gi] & ~wdata_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tag_reg        <= '0;
      op_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wr_reg         <= 1'b0;
      old_reg        <= '0;
      exc_reg        <= 1'b0;
      rd_en_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      csrf_wdata_reg <= '0;
      done_valid_reg <= 1'b0;
      done_tag_reg   <= '0;
      done_rdata_reg <= '0;
      done_exc_reg   <= 1'b0;
    end else begin
      rd_en_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      done_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tag_reg   <= bus.req_tag;
            op_reg    <= bus.req_op;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            wr_reg    <= bus.req_wr;
            state_reg <= WAIT_HEAD;
          end
        end
        WAIT_HEAD: begin
          // A flush coinciding with the head match still wins: the op was squashed.
          if (bus.flush) begin
            addr_reg  <= '0;
            state_reg <= IDLE;
          end else if (head_match) begin
            rd_en_reg <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          if (bus.flush) begin
            addr_reg  <= '0;
            state_reg <= IDLE;
          end else begin
            old_reg        <= bus.csrf_rdata;
            exc_reg        <= exc_next;
            wr_en_reg      <= wr_reg && !exc_next;
            csrf_wdata_reg <= merge_next;
            state_reg      <= WRITE;
          end
        end
        WRITE: begin
          // Past this point the op is committed at the head, so flush is ignored.
          done_valid_reg <= 1'b1;
          done_tag_reg   <= tag_reg;
          done_rdata_reg <= old_reg;
          done_exc_reg   <= exc_reg;
          csrf_wdata_reg <= '0;
          state_reg      <= DONE;
        end
        DONE: begin
          addr_reg  <= '0;
          state_reg <= IDLE;
        end
        default: begin
          addr_reg  <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.csrf_rd_en   = rd_en_reg;
  assign bus.csrf_addr    = addr_reg;
  assign bus.csrf_wr_en   = wr_en_reg;
  assign bus.csrf_wdata   = csrf_wdata_reg;
  assign bus.done_valid   = done_valid_reg;
  assign bus.done_tag     = done_tag_reg;
  assign bus.done_rdata   = done_rdata_reg;
  assign bus.done_exc     = done_exc_reg;
  assign bus.rename_stall = (state_reg != IDLE) || accept;
endmodule

// File: tb/tb_csr_exec_sequencer.sv
// Bench for csr_exec_sequencer: a 16-entry CSR file at 0x300-0x30F (everything else illegal)
// and a reference model that predicts each op's outcome from the head/flush timing.
module tb_csr_exec_sequencer;
  localparam int XLEN  = 64;
  localparam int TAG_W = 6;

  typedef struct {
    logic        acc_ready;
    int          stall_err;
    int          rd_n;
    int          wr_n;
    int          done_n;
    int          lat;
    logic [63:0] wdata;
    logic [5:0]  tag;
    logic [63:0] rdata;
    logic        exc;
  } obs_t;

  typedef struct {
    int          rd;
    int          wr;
    int          done;
    int          lat;
    logic        exc;
    logic [63:0] old;
    logic [63:0] nval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] env_csr [16];
  logic [63:0] ref_csr [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [63:0] poke_val = '0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  csr_exec_sequencer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  csr_exec_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  assign bus.csrf_rdata   = env_csr[bus.csrf_addr[3:0]];
  assign bus.csrf_illegal = (bus.csrf_addr[11:4] != 8'h30);

  always @(posedge clk) begin
    if (poke_en) env_csr[poke_idx] <= poke_val;
    else if (bus.csrf_wr_en) env_csr[bus.csrf_addr[3:0]] <= bus.csrf_wdata;
  end

  task automatic poke(input logic [3:0] idx, input logic [63:0] val);
    poke_idx = idx; poke_val = val; poke_en = 1'b1; ref_csr[idx] = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Reference: head match seen at cycle max(1,head_delay) after accept; flush up to that
  // cycle kills the op before the read, flush one cycle later kills it after the read.
  task automatic model_op(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                          input logic wr, input int head_delay, input int flush_at, output exp_t e);
    int match_cyc;
    bit kill_pre_read;
    bit kill_in_read;
    match_cyc     = (head_delay < 1) ? 1 : head_delay;
    kill_pre_read = (flush_at >= 1) && (flush_at <= match_cyc);
    kill_in_read  = (flush_at == match_cyc + 1);
    e.old = ref_csr[addr[3:0]];
    e.exc = (addr[11:4] != 8'h30) || (op == 2'b11);
    case (op)
      2'b00:   e.nval = wd;
      2'b01:   e.nval = e.old | wd;
      2'b10:   e.nval = e.old & ~wd;
      default: e.nval = e.old;
    endcase
    e.rd   = kill_pre_read ? 0 : 1;
    e.done = (kill_pre_read || kill_in_read) ? 0 : 1;
    e.wr   = (e.done == 1 && wr && !e.exc) ? 1 : 0;
    e.lat  = match_cyc + 3;
    if (e.wr == 1) ref_csr[addr[3:0]] = e.nval;
  endtask

  task automatic set_head(input logic [5:0] tag, input bit at_head);
    if (at_head) begin
      bus.rob_head_valid = 1'b1; bus.rob_head_tag = tag;
    end else if ($urandom_range(1) == 1) begin
      bus.rob_head_valid = 1'b0; bus.rob_head_tag = tag;
    end else begin
      bus.rob_head_valid = 1'b1; bus.rob_head_tag = tag + 6'd1;
    end
  endtask

  // Offers one op in an idle cycle and records what the DUT does over the following cycles.
  task automatic drive_op(input logic [5:0] tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [63:0] wd, input logic wr, input int head_delay,
                          input int flush_at, output obs_t o);
    int m;
    m = (head_delay < 1) ? 1 : head_delay;
    o = '{acc_ready: 1'b0, stall_err: 0, rd_n: 0, wr_n: 0, done_n: 0, lat: -1,
          wdata: '0, tag: '0, rdata: '0, exc: 1'b0};
    bus.req_valid = 1'b1; bus.req_tag = tag; bus.req_op = op; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_wr = wr; bus.flush = 1'b0;
    set_head(tag, head_delay == 0);
    @(negedge clk);
    o.acc_ready = bus.req_ready;
    if (!bus.rename_stall) o.stall_err++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_tag = 6'($urandom); bus.req_op = 2'($urandom);
    bus.req_addr = 12'($urandom); bus.req_wdata = {$urandom, $urandom}; bus.req_wr = 1'($urandom);
    for (int i = 1; i <= m + 5; i++) begin
      set_head(tag, i >= head_delay);
      bus.flush = (i == flush_at);
      @(negedge clk);
      if (bus.csrf_rd_en) o.rd_n++;
      if (bus.csrf_wr_en) begin o.wr_n++; o.wdata = bus.csrf_wdata; end
      if (bus.done_valid) begin
        o.done_n++; o.lat = i; o.tag = bus.done_tag; o.rdata = bus.done_rdata; o.exc = bus.done_exc;
      end
      if (i <= m + 3 && !(flush_at >= 1 && flush_at <= m + 1 && i > flush_at))
        if (!bus.rename_stall || bus.req_ready) o.stall_err++;
      @(posedge clk); #1;
    end
    bus.flush = 1'b0; bus.rob_head_valid = 1'b0;
    $display("txn tag=%0d op=%0d addr=%03h hd=%0d fl=%0d rd=%0d wr=%0d done=%0d lat=%0d old=%h exc=%0d",
             tag, op, addr, head_delay, flush_at, o.rd_n, o.wr_n, o.done_n, o.lat, o.rdata, o.exc);
  endtask

  task automatic test_reset;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.rename_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.rename_stall); else pass_cnt++;
    total_cnt++; if (bus.csrf_rd_en !== 1'b0 || bus.csrf_wr_en !== 1'b0)
      $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", bus.csrf_rd_en, bus.csrf_wr_en); else pass_cnt++;
    total_cnt++; if (bus.csrf_addr !== 12'h0 || bus.csrf_wdata !== 64'h0)
      $display("FAIL reset_csrf_bus: addr=%h wdata=%h want 0", bus.csrf_addr, bus.csrf_wdata); else pass_cnt++;
    total_cnt++; if (bus.done_valid !== 1'b0 || bus.done_tag !== 6'h0 || bus.done_rdata !== 64'h0 || bus.done_exc !== 1'b0)
      $display("FAIL reset_done: v=%b tag=%h rdata=%h exc=%b want all 0", bus.done_valid, bus.done_tag, bus.done_rdata, bus.done_exc);
    else pass_cnt++;
  endtask

  task automatic test_rs;
    obs_t o; exp_t e;
    poke(4'h1, 64'h0F);
    model_op(2'b01, 12'h301, 64'hF0, 1'b1, 0, 0, e);
    drive_op(6'd5, 2'b01, 12'h301, 64'hF0, 1'b1, 0, 0, o);
    total_cnt++; if (o.acc_ready !== 1'b1) $display("FAIL rs_accept: ready=%b want 1", o.acc_ready); else pass_cnt++;
    total_cnt++; if (o.wr_n !== 1 || o.wdata !== 64'hFF) $display("FAIL rs_write: n=%0d wdata=%h want 1 ff", o.wr_n, o.wdata); else pass_cnt++;
    total_cnt++; if (o.done_n !== 1 || o.rdata !== 64'h0F || o.tag !== 6'd5)
      $display("FAIL rs_done: n=%0d rdata=%h tag=%0d want 1 0f 5", o.done_n, o.rdata, o.tag); else pass_cnt++;
    total_cnt++; if (o.lat !== 4) $display("FAIL rs_latency: got %0d want 4", o.lat); else pass_cnt++;
    total_cnt++; if (env_csr[1] !== e.nval) $display("FAIL rs_csr_value: got %h want %h", env_csr[1], e.nval); else pass_cnt++;
    total_cnt++; if (bus.done_valid !== 1'b0 || bus.done_rdata !== 64'h0F)
      $display("FAIL rs_done_hold: v=%b rdata=%h want 0 0f", bus.done_valid, bus.done_rdata); else pass_cnt++;
  endtask

  task automatic test_rc_wait;
    obs_t o; exp_t e;
    poke(4'h2, 64'hFF);
    model_op(2'b10, 12'h302, 64'h0F, 1'b1, 10, 0, e);
    drive_op(6'd33, 2'b10, 12'h302, 64'h0F, 1'b1, 10, 0, o);
    total_cnt++; if (o.wr_n !== 1 || o.wdata !== 64'hF0) $display("FAIL rc_write: n=%0d wdata=%h want 1 f0", o.wr_n, o.wdata); else pass_cnt++;
    total_cnt++; if (o.stall_err !== 0) $display("FAIL rc_stall: %0d cycles without stall, want 0", o.stall_err); else pass_cnt++;
    total_cnt++; if (o.lat !== e.lat || o.rdata !== 64'hFF)
      $display("FAIL rc_done: lat=%0d rdata=%h want %0d ff", o.lat, o.rdata, e.lat); else pass_cnt++;
  endtask

  task automatic test_illegal;
    obs_t o; exp_t e;
    poke(4'h3, 64'hA5A5_0000_1234_5678);
    model_op(2'b00, 12'h7C3, 64'h1, 1'b1, 2, 0, e);
    drive_op(6'd12, 2'b00, 12'h7C3, 64'h1, 1'b1, 2, 0, o);
    total_cnt++; if (o.wr_n !== 0) $display("FAIL illegal_no_write: got %0d writes want 0", o.wr_n); else pass_cnt++;
    total_cnt++; if (o.done_n !== 1 || o.exc !== 1'b1 || o.rdata !== 64'hA5A5_0000_1234_5678)
      $display("FAIL illegal_done: n=%0d exc=%b rdata=%h want 1 1 a5a5000012345678", o.done_n, o.exc, o.rdata); else pass_cnt++;
  endtask

  task automatic test_flush_wait;
    obs_t o; exp_t e;
    model_op(2'b00, 12'h304, 64'h77, 1'b1, 6, 3, e);
    drive_op(6'd40, 2'b00, 12'h304, 64'h77, 1'b1, 6, 3, o);
    total_cnt++; if (o.rd_n !== 0 || o.wr_n !== 0 || o.done_n !== 0)
      $display("FAIL flush_wait: rd=%0d wr=%0d done=%0d want 0 0 0", o.rd_n, o.wr_n, o.done_n); else pass_cnt++;
    model_op(2'b01, 12'h304, 64'h77, 1'b1, 4, 4, e);
    drive_op(6'd41, 2'b01, 12'h304, 64'h77, 1'b1, 4, 4, o);
    total_cnt++; if (o.rd_n !== 0 || o.wr_n !== 0 || o.done_n !== 0)
      $display("FAIL flush_at_match: rd=%0d wr=%0d done=%0d want 0 0 0", o.rd_n, o.wr_n, o.done_n); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b1 || bus.csrf_addr !== 12'h0)
      $display("FAIL flush_idle: ready=%b addr=%h want 1 000", bus.req_ready, bus.csrf_addr); else pass_cnt++;
  endtask

  task automatic test_flush_write;
    obs_t o; exp_t e;
    poke(4'h6, 64'h100);
    model_op(2'b00, 12'h306, 64'hBEEF, 1'b1, 0, 3, e);
    drive_op(6'd63, 2'b00, 12'h306, 64'hBEEF, 1'b1, 0, 3, o);
    total_cnt++; if (o.wr_n !== 1 || o.wdata !== 64'hBEEF || o.done_n !== 1 || o.rdata !== 64'h100)
      $display("FAIL flush_in_write: wr=%0d wdata=%h done=%0d rdata=%h want 1 beef 1 100", o.wr_n, o.wdata, o.done_n, o.rdata);
    else pass_cnt++;
    model_op(2'b11, 12'h306, 64'h1, 1'b1, 0, 4, e);
    drive_op(6'd0, 2'b11, 12'h306, 64'h1, 1'b1, 0, 4, o);
    total_cnt++; if (o.wr_n !== 0 || o.done_n !== 1 || o.exc !== 1'b1 || o.rdata !== 64'hBEEF)
      $display("FAIL reserved_op: wr=%0d done=%0d exc=%b rdata=%h want 0 1 1 beef", o.wr_n, o.done_n, o.exc, o.rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write;
    poke(4'h5, 64'h1234_5678_9ABC_DEF0);
    bus.req_valid = 1'b1; bus.req_tag = 6'd9; bus.req_op = 2'b00; bus.req_addr = 12'h305;
    bus.req_wdata = 64'hDEAD; bus.req_wr = 1'b1; bus.rob_head_valid = 1'b1; bus.rob_head_tag = 6'd9;
    @(negedge clk);
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++; if (bus.csrf_wr_en !== 1'b1) $display("FAIL rst_write_active: wr_en=%b want 1", bus.csrf_wr_en); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.csrf_wr_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.rename_stall !== 1'b0 || bus.csrf_addr !== 12'h0)
      $display("FAIL rst_mid_write: wr_en=%b ready=%b stall=%b addr=%h want 0 1 0 000",
               bus.csrf_wr_en, bus.req_ready, bus.rename_stall, bus.csrf_addr);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.rob_head_valid = 1'b0;
    total_cnt++; if (env_csr[5] !== ref_csr[5] || bus.done_valid !== 1'b0)
      $display("FAIL rst_no_commit: csr=%h done_valid=%b want %h 0", env_csr[5], bus.done_valid, ref_csr[5]); else pass_cnt++;
  endtask

  task automatic test_random;
    obs_t o; exp_t e;
    logic [5:0] tag; logic [1:0] op; logic [11:0] addr; logic [63:0] wd; logic wr;
    int hd; int fa; int m;
    for (int n = 0; n < 40; n++) begin
      tag  = 6'($urandom);
      op   = 2'($urandom);
      addr = ($urandom_range(9) < 8) ? {8'h30, 4'($urandom)} : {8'h7C, 4'($urandom)};
      wd   = {$urandom, $urandom};
      wr   = 1'($urandom);
      hd   = int'($urandom_range(6));
      m    = (hd < 1) ? 1 : hd;
      fa   = ($urandom_range(1) == 1) ? 0 : int'($urandom_range(m + 4, 1));
      model_op(op, addr, wd, wr, hd, fa, e);
      drive_op(tag, op, addr, wd, wr, hd, fa, o);
      total_cnt++; if (o.acc_ready !== 1'b1 || o.stall_err !== 0)
        $display("FAIL rand%0d_handshake: ready=%b stall_err=%0d want 1 0", n, o.acc_ready, o.stall_err); else pass_cnt++;
      total_cnt++; if (o.rd_n !== e.rd || o.wr_n !== e.wr || o.done_n !== e.done)
        $display("FAIL rand%0d_events: rd=%0d wr=%0d done=%0d want %0d %0d %0d", n, o.rd_n, o.wr_n, o.done_n, e.rd, e.wr, e.done);
      else pass_cnt++;
      if (e.done == 1) begin
        total_cnt++; if (o.lat !== e.lat || o.tag !== tag || o.rdata !== e.old || o.exc !== e.exc)
          $display("FAIL rand%0d_done: lat=%0d tag=%0d rdata=%h exc=%b want %0d %0d %h %b",
                   n, o.lat, o.tag, o.rdata, o.exc, e.lat, tag, e.old, e.exc);
        else pass_cnt++;
      end
      if (e.wr == 1) begin
        total_cnt++; if (o.wdata !== e.nval) $display("FAIL rand%0d_wdata: got %h want %h", n, o.wdata, e.nval); else pass_cnt++;
      end
      total_cnt++; if (env_csr[addr[3:0]] !== ref_csr[addr[3:0]])
        $display("FAIL rand%0d_csr: got %h want %h", n, env_csr[addr[3:0]], ref_csr[addr[3:0]]); else pass_cnt++;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_op = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wr = 1'b0; bus.rob_head_valid = 1'b0; bus.rob_head_tag = '0;
    bus.flush = 1'b0;
    for (int i = 0; i < 16; i++) poke(4'(i), {$urandom, $urandom});
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    @(posedge clk); #1;
    test_rs();
    test_rc_wait();
    test_illegal();
    test_flush_wait();
    test_flush_write();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
